// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : matmul_pkg
//  Purpose  : Shared constants and FSM state type for the matrix SRAM blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    localparam int MEM_DEPTH = 543;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with occupancy count; resets to empty.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter  int DEPTH = 3,
    parameter  int WIDTH = 9,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        count    = count_q;
        pop_data = mem_q[rd_ptr_q];
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/sram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : sram_stream_reader
//  Purpose  : Streams a contiguous SRAM byte range out over valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_stream_reader #(
    parameter int ADDR_W     = matmul_pkg::ADDR_W,
    parameter int DATA_W     = matmul_pkg::DATA_W,
    parameter int MEM_DEPTH  = matmul_pkg::MEM_DEPTH,
    parameter int FIFO_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready
);

    import matmul_pkg::*;

    localparam int              CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(MEM_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic              err_q, err_d;
    logic              zero_done_q, zero_done_d;

    logic [DATA_W:0]   fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_pop;
    logic              pop_last;
    logic              room;
    logic              issue;
    logic [ADDR_W:0]   end_sum;
    logic              range_bad;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data ({inflight_last_q, sram_dout}),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Issue depends only on occupancy, never on out_ready.
    assign room      = !fifo_full &&
                       (({1'b0, fifo_count} + (CNT_W + 1)'(inflight_q)) < (CNT_W + 1)'(FIFO_DEPTH));
    assign issue     = (state_q == READ) && (rem_q != '0) && room;
    assign fifo_pop  = !fifo_empty && out_ready;
    assign pop_last  = fifo_pop && fifo_dout[DATA_W];
    assign end_sum   = {1'b0, base_addr} + {1'b0, length};
    assign range_bad = (base_addr >= ADDR_W'(MEM_DEPTH)) || (end_sum > DEPTH_X);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            sram_addr_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            err_q           <= 1'b0;
            zero_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            sram_addr_q     <= sram_addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            err_q           <= err_d;
            zero_done_q     <= zero_done_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        sram_addr_d     = sram_addr_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        err_d           = 1'b0;
        zero_done_d     = 1'b0;

        if (issue) begin
            sram_addr_d     = addr_q;
            inflight_d      = 1'b1;
            inflight_last_d = (rem_q == ADDR_W'(1));
            addr_d          = addr_q + 1'b1;
            rem_d           = rem_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (range_bad) begin
                        err_d = 1'b1;
                    end else if (length == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        addr_d  = base_addr;
                        rem_d   = length;
                        state_d = READ;
                    end
                end
            end
            // The final byte can handshake while still in READ.
            READ: begin
                if (pop_last) begin
                    state_d = DONE;
                end else if ((rem_q == '0) && !inflight_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q == READ) || (state_q == DRAIN);
        done      = zero_done_q || (state_q == DONE);
        err       = err_q;
        sram_we   = 1'b0;
        sram_addr = issue ? addr_q : sram_addr_q;
        out_valid = !fifo_empty;
        out_data  = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
        out_last  = !fifo_empty && fifo_dout[DATA_W];
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_stream_reader
//  Purpose  : Self-checking bench for sram_stream_reader against a range model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_stream_reader;

    localparam int MEM_DEPTH = 543;

    typedef struct {
        int base;
        int len;
        int mode;
        bit exp_err;
        bit exp_done;
    } cmd_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] base_addr;
    logic [9:0] length;
    logic       busy;
    logic       done;
    logic       err;
    logic       sram_we;
    logic [9:0] sram_addr;
    logic [7:0] sram_dout;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;

    logic [7:0] mem [1024];
    logic [5:0] ready_pat = 6'b101001;
    int         ready_mode = 0;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    logic [8:0] rx_q [$];
    int         rx_cyc [$];
    int         done_cnt = 0, err_cnt = 0, busy_cnt = 0, valid_cnt = 0;
    int         stall_errs = 0, we_errs = 0;
    int         done_cyc = -1, err_cyc = -1;
    bit         prev_stall = 0;
    logic [7:0] prev_data;
    logic       prev_last;

    sram_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_dout (sram_dout),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always @(posedge clk) sram_dout <= mem[sram_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ready_pat[cyc % 6];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Observer: records handshakes and pulses, checks stream stability.
    initial begin
        forever begin
            @(negedge clk);
            if (sram_we !== 1'b0) we_errs++;
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
                    stall_errs++;
                if (out_valid && out_ready) begin
                    rx_q.push_back({out_last, out_data});
                    rx_cyc.push_back(cyc);
                end
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (err)  begin err_cnt++;  err_cyc = cyc;  end
                if (busy) busy_cnt++;
                if (out_valid) valid_cnt++;
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input int b, input int l, input int mode,
                           input bit exp_err, input bit exp_done, input int extra_at);
        int r0  = rx_q.size();
        int d0  = done_cnt;
        int e0  = err_cnt;
        int bz0 = busy_cnt;
        int v0  = valid_cnt;
        int s0  = stall_errs;
        int t0;
        int nexp;
        int ngot;
        bit seen = 0;
        logic [8:0] exp_b;
        ready_mode = mode;
        @(posedge clk);
        #1;
        base_addr = 10'(b);
        length    = 10'(l);
        start     = 1'b1;
        t0        = cyc;
        for (int k = 1; k <= 3000; k++) begin
            @(posedge clk);
            #1;
            if (k == extra_at) begin
                start = 1'b1; base_addr = 10'd0; length = 10'd5;
            end else begin
                start = 1'b0;
            end
            if (done_cnt != d0 || err_cnt != e0) begin seen = 1; break; end
        end
        start = 1'b0;
        if (!seen) chk("cmd_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        nexp = exp_err ? 0 : l;
        ngot = rx_q.size() - r0;
        chk("err_pulses", err_cnt - e0, exp_err ? 1 : 0);
        chk("done_pulses", done_cnt - d0, exp_done ? 1 : 0);
        chk("busy_after", busy, 0);
        chk("stall_stable", stall_errs - s0, 0);
        chk("byte_count", ngot, nexp);
        for (int i = 0; i < nexp && i < ngot; i++) begin
            exp_b = {(i == l - 1), mem[b + i]};
            chk($sformatf("byte[%0d]@%0d", i, b + i), rx_q[r0 + i], exp_b);
        end
        if (exp_err) begin
            chk("err_timing", err_cyc, t0 + 1);
            chk("err_no_busy", busy_cnt - bz0, 0);
            chk("err_no_valid", valid_cnt - v0, 0);
        end else if (l == 0) begin
            chk("zero_done_timing", done_cyc, t0 + 1);
            chk("zero_no_valid", valid_cnt - v0, 0);
        end else if (mode == 0 && ngot == nexp) begin
            chk("first_valid_cyc", rx_cyc[r0], t0 + 3);
            chk("last_byte_cyc", rx_cyc[r0 + nexp - 1], t0 + 2 + l);
            chk("done_timing", done_cyc, t0 + 3 + l);
            chk("busy_cycles", busy_cnt - bz0, l + 2);
        end
    endtask

    cmd_t tbl [10];

    initial begin
        int b;
        int l;
        int r0;
        int d0;
        bit e;

        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        mem[10] = 8'h11; mem[11] = 8'h22; mem[12] = 8'h33; mem[13] = 8'h44;

        tbl[0] = '{10,   4,   0, 0, 1};
        tbl[1] = '{10,   4,   1, 0, 1};
        tbl[2] = '{542,  1,   0, 0, 1};
        tbl[3] = '{540,  4,   0, 1, 0};
        tbl[4] = '{600,  1,   0, 1, 0};
        tbl[5] = '{0,    0,   0, 0, 1};
        tbl[6] = '{0,    543, 0, 0, 1};
        tbl[7] = '{530,  13,  2, 0, 1};
        tbl[8] = '{530,  14,  0, 1, 0};
        tbl[9] = '{1023, 0,   0, 1, 0};

        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_we", sram_we, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_cmd(tbl[i].base, tbl[i].len, tbl[i].mode, tbl[i].exp_err, tbl[i].exp_done, -1);
            if (i == 0) begin
                chk("basic_b0", rx_q[rx_q.size() - 4], 9'h011);
                chk("basic_b3", rx_q[rx_q.size() - 1], 9'h144);
            end
            if (i == 2) chk("top_byte", rx_q[rx_q.size() - 1], 9'h11E);
            if (i == 6) chk("full_last", rx_q[rx_q.size() - 1], 9'h11E);
        end

        // A second start while busy must not disturb the running command.
        run_cmd(100, 10, 1, 0, 1, 4);

        // Reset in the middle of a command.
        ready_mode = 0;
        r0 = rx_q.size();
        d0 = done_cnt;
        @(posedge clk);
        #1;
        base_addr = 10'd200; length = 10'd8; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 50 && (rx_q.size() - r0) < 2; k++) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_bytes", ((rx_q.size() - r0) >= 2) ? 1 : 0, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_no_done", done_cnt - d0, 0);
        run_cmd(10, 4, 0, 0, 1, -1);

        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 12; n++) begin
            b = $urandom_range(0, 560);
            l = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 20) : $urandom_range(0, 60);
            e = (b >= MEM_DEPTH) || (b + l > MEM_DEPTH);
            run_cmd(b, l, $urandom_range(0, 2), e, !e, -1);
        end

        chk("sram_we_never", we_errs, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
- Read-side companion to the matrix SRAM: on a start command, fetches a contiguous run of bytes (one matrix or row) from the 543 x 8 single-port SRAM and streams them downstream over a valid/ready interface.
- Sits between the SRAM and the multiply datapath.
- Absorbs the SRAM's 1-cycle registered read latency and downstream backpressure with a small FIFO.
- Sustains 1 byte/cycle when downstream is always ready.

Parameters:
- ADDR_W, 10, SRAM address width.
- DATA_W, 8, SRAM/stream data width.
- MEM_DEPTH, 543, number of valid SRAM locations (0..MEM_DEPTH-1).
- FIFO_DEPTH, 3, output buffer entries; minimum 3 for full throughput.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  command strobe, sampled in IDLE only.
- base_addr  in  ADDR_W  first SRAM address.
- length  in  ADDR_W  byte count, 0..MEM_DEPTH.
- busy  out  1  high from accepted start until done/err.
- done  out  1  1-cycle pulse after the last byte handshakes.
- err  out  1  1-cycle pulse on a rejected (out-of-range) command.
- sram_we  out  1  tied 0; this block never writes.
- sram_addr  out  ADDR_W  SRAM address.
- sram_dout  in  DATA_W  SRAM registered read data.
- out_valid  out  1  stream data valid.
- out_data  out  DATA_W  stream byte (FIFO head).
- out_last  out  1  qualifies the final byte of the command.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset values: busy=0, done=0, err=0, sram_we=0, sram_addr=0, out_valid=0, out_last=0, out_data=0. FIFO is emptied, in-flight flag cleared, state=IDLE.
- SRAM timing: the address presented in cycle t with we=0 appears on sram_dout in cycle t+1. The SRAM reads every cycle, so capture is qualified only by an internal in-flight flag. sram_addr holds its value while no read is issued.
- FSM IDLE:
  - On start, range-check base_addr and length.
  - If base_addr >= MEM_DEPTH, or base_addr+length > MEM_DEPTH (computed at ADDR_W+1 bits): err pulses the next cycle and the FSM stays in IDLE. No reads are issued.
  - Else if length==0: done pulses the next cycle, no output, FSM stays in IDLE.
  - Else: latch base_addr and length into the address and remaining counters, busy=1, go to READ.
- FSM READ:
  - Issue a read when remaining>0 and fifo_count+inflight < FIFO_DEPTH. Issuing means sram_addr=current address, inflight set for the next cycle, address+1, remaining-1.
  - In the cycle after an issue, push sram_dout into the FIFO. The byte pushed for the final address is tagged last.
  - This issue rule has no combinational path from out_ready to sram_addr.
  - When remaining==0, inflight==0 and the FIFO holds only data not yet handshaken, go to DRAIN (may be merged into READ).
- FSM DRAIN: wait for the last-tagged byte to handshake (out_valid && out_ready && out_last), then go to DONE.
- FSM DONE: done=1 for one cycle, busy=0, return to IDLE. A start in this cycle is ignored.
- Stream rules:
  - out_valid = FIFO non-empty.
  - out_data and out_last must stay stable while out_valid && !out_ready.
  - Pop on out_valid && out_ready.
  - A push and a pop in the same cycle leave the count unchanged.
- Latency: start high in cycle 0 gives sram_addr=base in cycle 1, FIFO push at end of cycle 2, and out_valid=1 in cycle 3.
- Throughput: 1 byte/cycle with out_ready held high; bytes are contiguous and in ascending address order.
- start while busy: ignored, with no effect on the current command.
- Wrap-around: none. The address never exceeds MEM_DEPTH-1 because of the range check.
- Reset mid-command: returns to IDLE the next cycle, drops in-flight data and FIFO contents, out_valid=0, no done pulse.

Decomposition:
- Shared package matmul_pkg: MEM_DEPTH=543, ADDR_W=10, DATA_W=8, FSM state enum {IDLE, READ, DRAIN, DONE}.
- One sub-module, sync_fifo: synchronous, depth FIFO_DEPTH, width DATA_W+1 (data plus last tag), push/pop/count/empty/full, reset to empty.
- The FSM, counters and range check stay in sram_stream_reader.

Test Plan:
- Basic read: preload mem[10..13]=0x11,0x22,0x33,0x44; start base=10 len=4 with out_ready=1.
  -> out_valid first in cycle 3; bytes 11,22,33,44 on consecutive cycles; out_last on 0x44; done the cycle after; busy low after.
- Backpressure: same preload with out_ready toggled 1,0,0,1,0,1...
  -> identical byte order; no loss or duplication; data stable while stalled; at most FIFO_DEPTH buffered; sram_we always 0.
- Boundaries:
  -> base=542 len=1 returns mem[542] with out_last=1.
  -> base=540 len=4 gives an err pulse, zero out_valid, busy stays 0.
  -> base=600 len=1 gives an err pulse.
  -> len=0 gives a done pulse with no output.
- Full memory: base=0 len=543, mem[i]=i[7:0], out_ready=1.
  -> 543 bytes in 543 consecutive cycles; last byte 0x1E with out_last.
- Start while busy: second start (base=0) mid-command.
  -> ignored; the original stream completes unchanged; exactly one done.
- Reset mid-command: assert rst after 2 bytes delivered of a len=8 read.
  -> next cycle out_valid=0, busy=0, no done; a fresh command afterwards behaves as the basic read.
